multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase names them: `clk` and `rst_n`.
REQ-002 The ports SHALL be as follows, one per line (name, direction, width, meaning):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  async active-low reset
- `instr`  in  32  current IR contents; stable from DECODE through WB
- `zero`  in  1  ALU zero flag; valid in EXEC
- `PC_Wr`  out  1  PC write enable
- `IR_Wr`  out  1  IR write enable
- `NPC_Sel`  out  2  next-PC source: 00 PC+4, 01 branch target, 10 jump target
- `EXT_Op`  out  1  to extender: 0 zero-extend, 1 sign-extend
- `ALU_SrcB`  out  1  ALU B operand: 0 rt data, 1 extended immediate
- `ALU_Op`  out  2  ALU function: 00 add, 01 sub, 10 or, 11 lui (B<<16)
- `Mem_Wr`  out  1  data memory write enable
- `Mem_ToReg`  out  1  write-back source: 0 ALU result, 1 memory data
- `Reg_Dst`  out  1  destination register: 0 rt, 1 rd
- `Reg_Wr`  out  1  register file write enable
- `state`  out  3  current state, for debug

Function
REQ-003 Decode SHALL use opcode `instr[31:26]`, with funct `instr[5:0]` when the opcode is 000000. The supported instructions SHALL be:
- addu: funct 100001
- subu: funct 100011
- ori: 001101
- lui: 001111
- lw: 100011
- sw: 101011
- beq: 000100
- j: 000010

Any other encoding is "unknown".

REQ-004 The state encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 are illegal and SHALL transition to FETCH with all enables 0.

REQ-005 The state register SHALL update on the rising edge of `clk`. Outputs SHALL be combinational functions of `state` and `instr` (Moore-style per state).

REQ-006 FETCH: `IR_Wr`=1, `PC_Wr`=1, `NPC_Sel`=00. Next state is DECODE unconditionally.

REQ-007 DECODE:
- j: `PC_Wr`=1, `NPC_Sel`=10, next state FETCH.
- unknown: no enables asserted, next state FETCH (treated as nop).
- all other supported instructions: next state EXEC.

REQ-008 EXEC:
- addu: `ALU_Op`=00, `ALU_SrcB`=0.
- subu and beq: `ALU_Op`=01, `ALU_SrcB`=0.
- ori: `ALU_Op`=10, `ALU_SrcB`=1.
- lui: `ALU_Op`=11, `ALU_SrcB`=1.
- lw and sw: `ALU_Op`=00, `ALU_SrcB`=1.

REQ-009 EXEC next state:
- beq: `PC_Wr`=`zero`, `NPC_Sel`=01, next state FETCH.
- lw, sw: next state MEM.
- addu, subu, ori, lui: next state WB.

REQ-010 MEM:
- sw: `Mem_Wr`=1 for exactly one cycle, next state FETCH.
- lw: no write, next state WB.

REQ-011 WB: `Reg_Wr`=1 for exactly one cycle, then next state FETCH.
- `Reg_Dst`=1 for addu and subu; 0 otherwise.
- `Mem_ToReg`=1 for lw; 0 otherwise.

REQ-012 `EXT_Op` SHALL be 1 for lw, sw and beq, and 0 for ori, lui and all other cases, in every state except FETCH. In FETCH, `EXT_Op` SHALL be 0.

REQ-013 `ALU_Op`, `ALU_SrcB`, `Reg_Dst` and `Mem_ToReg` SHALL hold their instruction-decoded values from EXEC through WB. They SHALL be 0 in FETCH and DECODE.

REQ-014 Instruction latencies SHALL be exactly:
- j: 2 cycles
- unknown: 2 cycles
- beq: 3 cycles
- sw: 4 cycles
- addu, subu, ori, lui: 4 cycles
- lw: 5 cycles

REQ-015 Each write enable (`PC_Wr`, `IR_Wr`, `Mem_Wr`, `Reg_Wr`) SHALL be asserted only in the states listed above and never in more than one cycle per instruction, except `PC_Wr` in FETCH plus a jump or branch.

Reset
REQ-016 While `rst_n`=0, `state` SHALL be FETCH and all outputs SHALL be 0, including `PC_Wr` and `IR_Wr`, which are forced low despite the FETCH state.

REQ-017 Assertion of `rst_n` SHALL take effect immediately (asynchronously), including mid-instruction. A partially executed sw or lw SHALL NOT complete, and no `Mem_Wr` or `Reg_Wr` pulse SHALL follow.

REQ-018 After `rst_n` is released, the first rising edge of `clk` SHALL be a FETCH cycle with `IR_Wr`=`PC_Wr`=1.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- `instr`=0x3C01_1234 (lui) -> states 0,1,2,4,0; `ALU_Op`=11, `ALU_SrcB`=1, `Reg_Wr`=1 in WB, `Reg_Dst`=0, `EXT_Op`=0.
- `instr`=0x8C22_FFFC (lw) -> states 0,1,2,3,4,0; `EXT_Op`=1 from DECODE onward, `Mem_Wr`=0 throughout, `Mem_ToReg`=1 in WB.
- `instr`=0x1022_0003 (beq): `zero`=1 in EXEC -> `PC_Wr`=1, `NPC_Sel`=01; rerun with `zero`=0 -> `PC_Wr`=0; both return to FETCH after 3 cycles.
- `instr`=0x0800_0010 (j) -> DECODE asserts `PC_Wr`=1, `NPC_Sel`=10; next state FETCH. `instr`=0xFC00_0000 (unknown) -> DECODE to FETCH with no enables asserted.
- sw 0xAC22_0004: pull `rst_n` low in EXEC -> `state` goes to 0 and all outputs go to 0 asynchronously; no `Mem_Wr` pulse; after release, first cycle has `IR_Wr`=1.
- Force `state`=6 -> next cycle is FETCH; a 1000-cycle random legal-instruction run shows no enable asserted outside its permitted state.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS-subset control FSM
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        PC_Wr,
  output logic        IR_Wr,
  output logic [1:0]  NPC_Sel,
  output logic        EXT_Op,
  output logic        ALU_SrcB,
  output logic [1:0]  ALU_Op,
  output logic        Mem_Wr,
  output logic        Mem_ToReg,
  output logic        Reg_Dst,
  output logic        Reg_Wr,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Held as raw bits so the unused codes 5-7 stay representable and recoverable.
  logic [2:0] state_q;
  logic [2:0] state_d;

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
  logic       is_alu_wb;
  logic       ext_sign;
  logic [1:0] alu_op_dec;
  logic       alu_srcb_dec;
  logic       unused_instr_bits;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  assign is_addu = (op == 6'b000000) && (funct == 6'b100001);
  assign is_subu = (op == 6'b000000) && (funct == 6'b100011);
  assign is_ori  = (op == 6'b001101);
  assign is_lui  = (op == 6'b001111);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);

  assign is_alu_wb    = is_addu | is_subu | is_ori | is_lui;
  assign ext_sign     = is_lw | is_sw | is_beq;
  assign alu_srcb_dec = is_ori | is_lui | is_lw | is_sw;
  assign alu_op_dec   = (is_subu | is_beq) ? 2'b01 :
                        is_ori             ? 2'b10 :
                        is_lui             ? 2'b11 : 2'b00;

  // Register fields and immediates are datapath concerns, not control.
  assign unused_instr_bits = ^instr[25:6];

  assign state = state_q;

  // State register; reset lands in FETCH immediately, even mid-instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and Moore outputs; everything is gated off while reset is held.
  always_comb begin
    state_d   = S_FETCH;
    PC_Wr     = 1'b0;
    IR_Wr     = 1'b0;
    NPC_Sel   = 2'b00;
    EXT_Op    = 1'b0;
    ALU_SrcB  = 1'b0;
    ALU_Op    = 2'b00;
    Mem_Wr    = 1'b0;
    Mem_ToReg = 1'b0;
    Reg_Dst   = 1'b0;
    Reg_Wr    = 1'b0;

    case (state_q)
      S_FETCH: begin
        PC_Wr   = 1'b1;
        IR_Wr   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        EXT_Op = ext_sign;
        if (is_j) begin
          PC_Wr   = 1'b1;
          NPC_Sel = 2'b10;
        end else if (is_alu_wb | is_lw | is_sw | is_beq) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC, S_MEM, S_WB: begin
        EXT_Op    = ext_sign;
        ALU_Op    = alu_op_dec;
        ALU_SrcB  = alu_srcb_dec;
        Reg_Dst   = is_addu | is_subu;
        Mem_ToReg = is_lw;
        if (state_q == S_EXEC) begin
          if (is_beq) begin
            PC_Wr   = zero;
            NPC_Sel = 2'b01;
          end else if (is_lw | is_sw) begin
            state_d = S_MEM;
          end else if (is_alu_wb) begin
            state_d = S_WB;
          end
        end else if (state_q == S_MEM) begin
          if (is_sw)      Mem_Wr  = 1'b1;
          else if (is_lw) state_d = S_WB;
        end else begin
          Reg_Wr = 1'b1;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (!rst_n) begin
      PC_Wr     = 1'b0;
      IR_Wr     = 1'b0;
      NPC_Sel   = 2'b00;
      EXT_Op    = 1'b0;
      ALU_SrcB  = 1'b0;
      ALU_Op    = 2'b00;
      Mem_Wr    = 1'b0;
      Mem_ToReg = 1'b0;
      Reg_Dst   = 1'b0;
      Reg_Wr    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - scoreboard bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        PC_Wr, IR_Wr, EXT_Op, ALU_SrcB, Mem_Wr, Mem_ToReg, Reg_Dst, Reg_Wr;
  logic [1:0]  NPC_Sel, ALU_Op;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero),
    .PC_Wr(PC_Wr), .IR_Wr(IR_Wr), .NPC_Sel(NPC_Sel), .EXT_Op(EXT_Op),
    .ALU_SrcB(ALU_SrcB), .ALU_Op(ALU_Op), .Mem_Wr(Mem_Wr),
    .Mem_ToReg(Mem_ToReg), .Reg_Dst(Reg_Dst), .Reg_Wr(Reg_Wr), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pc_wr;
    logic       ir_wr;
    logic [1:0] npc;
    logic       ext;
    logic       srcb;
    logic [1:0] aluop;
    logic       mem_wr;
    logic       m2r;
    logic       rdst;
    logic       reg_wr;
  } vec_t;

  typedef enum int {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_UNK} cls_t;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t act_vec();
    vec_t v;
    v.st = state;      v.pc_wr = PC_Wr;   v.ir_wr = IR_Wr;     v.npc = NPC_Sel;
    v.ext = EXT_Op;    v.srcb = ALU_SrcB; v.aluop = ALU_Op;    v.mem_wr = Mem_Wr;
    v.m2r = Mem_ToReg; v.rdst = Reg_Dst;  v.reg_wr = Reg_Wr;
    return v;
  endfunction

  function automatic cls_t classify(input logic [31:0] w);
    case (w[31:26])
      6'h00:   return (w[5:0] == 6'h21) ? C_ADDU : (w[5:0] == 6'h23) ? C_SUBU : C_UNK;
      6'h0D:   return C_ORI;
      6'h0F:   return C_LUI;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h02:   return C_J;
      default: return C_UNK;
    endcase
  endfunction

  function automatic logic [31:0] encode(input cls_t c);
    logic [31:0] r;
    logic [5:0]  op;
    r = $urandom;
    case (c)
      C_ADDU: return {6'h00, r[19:0], 6'h21};
      C_SUBU: return {6'h00, r[19:0], 6'h23};
      C_ORI:  return {6'h0D, r[25:0]};
      C_LUI:  return {6'h0F, r[25:0]};
      C_LW:   return {6'h23, r[25:0]};
      C_SW:   return {6'h2B, r[25:0]};
      C_BEQ:  return {6'h04, r[25:0]};
      C_J:    return {6'h02, r[25:0]};
      default: begin
        op = 6'($urandom_range(1, 63));
        while (classify({op, 26'd0}) != C_UNK) op = 6'($urandom_range(1, 63));
        return {op, r[25:0]};
      end
    endcase
  endfunction

  // Reference: the instruction's visit list of states, and what each state must show.
  task automatic push_instr(input logic [31:0] w, input logic z, output int lat);
    cls_t c;
    int   path[$];
    vec_t e;
    logic [1:0] aop;
    logic sb, ex, rd, mr;
    c = classify(w);
    case (c)
      C_ADDU, C_SUBU, C_ORI, C_LUI: path = '{0, 1, 2, 4};
      C_LW:                         path = '{0, 1, 2, 3, 4};
      C_SW:                         path = '{0, 1, 2, 3};
      C_BEQ:                        path = '{0, 1, 2};
      default:                      path = '{0, 1};
    endcase
    aop = (c == C_SUBU || c == C_BEQ) ? 2'd1 : (c == C_ORI) ? 2'd2 : (c == C_LUI) ? 2'd3 : 2'd0;
    sb  = (c == C_ORI || c == C_LUI || c == C_LW || c == C_SW);
    ex  = (c == C_LW || c == C_SW || c == C_BEQ);
    rd  = (c == C_ADDU || c == C_SUBU);
    mr  = (c == C_LW);
    foreach (path[k]) begin
      e = '0;
      e.st = 3'(path[k]);
      if (path[k] == 0) begin
        e.pc_wr = 1'b1; e.ir_wr = 1'b1;
      end else if (path[k] == 1) begin
        e.ext = ex;
        if (c == C_J) begin e.pc_wr = 1'b1; e.npc = 2'd2; end
      end else begin
        e.ext = ex; e.aluop = aop; e.srcb = sb; e.rdst = rd; e.m2r = mr;
        if (path[k] == 2 && c == C_BEQ) begin e.pc_wr = z; e.npc = 2'd1; end
        if (path[k] == 3 && c == C_SW) e.mem_wr = 1'b1;
        if (path[k] == 4) e.reg_wr = 1'b1;
      end
      exp_q.push_back(e);
    end
    lat = path.size();
  endtask

  // Called at a falling edge inside a FETCH cycle.
  task automatic run_instr(input logic [31:0] w, input logic z, output int lat);
    instr = w;
    zero  = z;
    push_instr(w, z, lat);
    repeat (lat) @(negedge clk);
  endtask

  // Monitor: every cycle with an outstanding expectation is compared in full.
  always @(negedge clk) begin
    vec_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("cycle st=%0d instr=%h", e.st, instr), 32'(act_vec()), 32'(e));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int cycles;
    rst_n = 1'b0;
    instr = 32'h8C22_FFFC;
    zero  = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outputs", 32'(act_vec()), 32'd0);

    rst_n = 1'b1;
    run_instr(32'h3C01_1234, 1'b0, lat);
    run_instr(32'h8C22_FFFC, 1'b0, lat);
    run_instr(32'h1022_0003, 1'b1, lat);
    run_instr(32'h1022_0003, 1'b0, lat);
    run_instr(32'h0800_0010, 1'b0, lat);
    run_instr(32'hFC00_0000, 1'b1, lat);
    run_instr(32'h0000_0000, 1'b0, lat);
    run_instr(32'h0022_0821, 1'b0, lat);
    run_instr(32'h0022_0823, 1'b0, lat);
    run_instr(32'h3421_00FF, 1'b0, lat);

    // Reset pulled during EXEC of a store: only FETCH and DECODE are expected.
    instr = 32'hAC22_0004;
    zero  = 1'b0;
    push_instr(instr, zero, lat);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    #3;
    chk("sw_in_exec", 32'(state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_outputs", 32'(act_vec()), 32'd0);
    repeat (2) begin
      @(negedge clk);
      #2;
      chk("no_mem_wr_in_reset", 32'({Mem_Wr, Reg_Wr, state}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(32'hAC22_0004, 1'b0, lat);

    // Illegal state code recovers to FETCH with no enables.
    force dut.state_q = 3'd6;
    #1;
    chk("illegal_state_seen", 32'(state), 32'd6);
    chk("illegal_no_enables", 32'({PC_Wr, IR_Wr, Mem_Wr, Reg_Wr}), 32'd0);
    release dut.state_q;
    @(posedge clk);
    #1;
    chk("illegal_to_fetch", 32'({state, IR_Wr, PC_Wr}), 32'({3'd0, 1'b1, 1'b1}));
    @(negedge clk);

    cycles = 0;
    while (cycles < 1000) begin
      run_instr(encode(cls_t'($urandom_range(0, 7))), 1'($urandom_range(0, 1)), lat);
      cycles += lat;
    end
    repeat (8) run_instr(encode(C_UNK), 1'($urandom_range(0, 1)), lat);

    @(negedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
